// File: rtl/synthesijer_mul_seq.sv
// synthesijer_mul_seq
// Sequential integer multiplier returning the full 2*WIDTH-bit product.
// BITS_PER_CYCLE multiplier bits are retired on each cycle. A result is
// ready WIDTH/BITS_PER_CYCLE + 1 cycles after the operands are accepted.
//
// Parameters:
//   WIDTH          operand width in bits (>= 2)
//   BITS_PER_CYCLE multiplier bits retired per iteration (divides WIDTH)
//   SIGNED         1 = two's-complement operands/product, 0 = unsigned
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   a, b       multiplicand / multiplier, sampled on an accepted nd
//   nd         new-data strobe, accepted only while busy = 0
//   result     low WIDTH bits of the last product (registered)
//   result_hi  high WIDTH bits of the last product (registered)
//   valid      one-cycle pulse when result/result_hi hold a new product
//   busy       high while an operation is running; nd is ignored then
module synthesijer_mul_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SIGNED         = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             nd,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             valid,
    output logic             busy
);

    localparam int ITER      = WIDTH / BITS_PER_CYCLE;
    localparam int CW        = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW        = WIDTH + BITS_PER_CYCLE;
    localparam int AW        = 2 * WIDTH + BITS_PER_CYCLE;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic                 neg_r;

    logic [PW-1:0]        mc_ext_s;
    logic [PW-1:0]        pp_s;
    logic [AW-1:0]        sum_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [2*WIDTH-1:0]   prod_s;

    // Unsigned magnitude of an operand; the most negative value maps to
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (IS_SIGNED && v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    // Two's-complement negation over the full product width.
    function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] v);
        negate2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // One iteration: add the partial product into the top of the accumulator,
    // then shift the accumulator right. After ITER steps the low-order
    // partial products have been shifted down into their final position.
    always_comb begin
        mc_ext_s = {{BITS_PER_CYCLE{1'b0}}, mcand_r};
        pp_s     = {PW{1'b0}};
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pp_s = pp_s + (mplier_r[i] ? (mc_ext_s << i) : {PW{1'b0}});
        end
        sum_s      = {{BITS_PER_CYCLE{1'b0}}, acc_r} + {pp_s, {WIDTH{1'b0}}};
        acc_next_s = (2*WIDTH)'(sum_s >> BITS_PER_CYCLE);
        prod_s     = neg_r ? negate2w(acc_next_s) : acc_next_s;
    end

    // Control FSM, operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            neg_r     <= 1'b0;
            result    <= {WIDTH{1'b0}};
            result_hi <= {WIDTH{1'b0}};
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (nd) begin
                        mcand_r  <= magnitude(a);
                        mplier_r <= magnitude(b);
                        neg_r    <= IS_SIGNED ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        cnt_r    <= CNT_LOAD;
                        busy     <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_r >> BITS_PER_CYCLE;
                    if (cnt_r == {CW{1'b0}}) begin
                        result    <= prod_s[WIDTH-1:0];
                        result_hi <= prod_s[2*WIDTH-1:WIDTH];
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r     <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synthesijer_mul_seq.sv
module tb_synthesijer_mul_seq;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] a0, b0, r0, h0;
    logic        nd0, v0, bz0;
    logic [31:0] a1, b1, r1, h1;
    logic        nd1, v1, bz1;
    logic [15:0] a2, b2, r2, h2;
    logic        nd2, v2, bz2;

    int checks   = 0;
    int failures = 0;

    logic [63:0] q [3][$];
    logic [63:0] last [3] = '{default: 64'd0};

    always #5 clk = ~clk;

    synthesijer_mul_seq #(.WIDTH(32), .BITS_PER_CYCLE(1), .SIGNED(1)) u0 (
        .clk(clk), .reset(reset), .a(a0), .b(b0), .nd(nd0),
        .result(r0), .result_hi(h0), .valid(v0), .busy(bz0));

    synthesijer_mul_seq #(.WIDTH(32), .BITS_PER_CYCLE(4), .SIGNED(1)) u1 (
        .clk(clk), .reset(reset), .a(a1), .b(b1), .nd(nd1),
        .result(r1), .result_hi(h1), .valid(v1), .busy(bz1));

    synthesijer_mul_seq #(.WIDTH(16), .BITS_PER_CYCLE(4), .SIGNED(0)) u2 (
        .clk(clk), .reset(reset), .a(a2), .b(b2), .nd(nd2),
        .result(r2), .result_hi(h2), .valid(v2), .busy(bz2));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Reference: exact integer product of w-bit operands, reduced mod 2^(2w).
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input bit sgn, input int w);
        longint      sx, sy;
        logic [63:0] p, m, tx, ty;
        if (sgn) begin
            tx = {x, 32'd0} << (32 - w);
            ty = {y, 32'd0} << (32 - w);
            sx = longint'(tx) >>> (64 - w);
            sy = longint'(ty) >>> (64 - w);
            p  = 64'(sx * sy);
        end else begin
            p = {32'd0, x} * {32'd0, y};
        end
        m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return p & m;
    endfunction

    task automatic mon(input int d, input logic v, input logic [63:0] got);
        logic [63:0] e;
        if (v) begin
            chk($sformatf("valid_expected_d%0d", d), 64'(q[d].size() > 0), 64'd1);
            if (q[d].size() > 0) begin
                e = q[d].pop_front();
                chk($sformatf("product_d%0d", d), got, e);
                last[d] = e;
            end
        end else begin
            chk($sformatf("hold_d%0d", d), got, last[d]);
        end
    endtask

    // Scoreboard monitor: compares every presented product, and checks that
    // outputs hold between completions.
    always @(negedge clk) begin
        if (reset) begin
            mon(0, v0, {h0, r0});
            mon(1, v1, {h1, r1});
            mon(2, v2, {32'd0, h2, r2});
        end
    end

    // One operation on u0; optionally injects an nd (2x2) while busy.
    task automatic run0(input logic [31:0] x, input logic [31:0] y, input int ignore_at);
        int n, bc;
        @(posedge clk); #1;
        a0 = x; b0 = y; nd0 = 1'b1;
        q[0].push_back(ref_mul(x, y, 1'b1, 32));
        n = 0; bc = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) nd0 = 1'b0;
            if (ignore_at > 0 && n == ignore_at) begin
                chk("busy_at_ignored_nd", 64'(bz0), 64'd1);
                a0 = 32'd2; b0 = 32'd2; nd0 = 1'b1;
            end
            if (ignore_at > 0 && n == ignore_at + 1) nd0 = 1'b0;
            bc += int'(bz0);
        end while (!v0 && n < 100);
        chk("latency_d0", 64'(n), 64'd33);
        chk("busy_cycles_d0", 64'(bc), 64'd32);
    endtask

    task automatic drive(input int d, input logic [31:0] x, input logic [31:0] y, input logic n);
        if (d == 1) begin
            a1 = x; b1 = y; nd1 = n;
        end else begin
            a2 = x[15:0]; b2 = y[15:0]; nd2 = n;
        end
    endtask

    function automatic logic vld(input int d);
        return (d == 1) ? v1 : v2;
    endfunction

    // Back-to-back stream: a new nd is raised in every valid cycle.
    task automatic b2b(input int d, input int w, input bit sgn, input int lat);
        logic [31:0] x, y, m;
        int n;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 100; k++) begin
            if (k == 0) begin
                x = sgn ? 32'h8000_0000 : m;
                y = x;
            end else if (k == 1) begin
                x = m; y = 32'd1;
            end else begin
                x = $urandom() & m;
                y = $urandom() & m;
            end
            drive(d, x, y, 1'b1);
            q[d].push_back(ref_mul(x, y, sgn, w));
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
                if (n == 1) drive(d, x, y, 1'b0);
            end while (!vld(d) && n < 50);
            chk($sformatf("interval_d%0d", d), 64'(n), 64'(lat));
        end
    endtask

    initial begin
        reset = 1'b0;
        nd0 = 1'b0; nd1 = 1'b0; nd2 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0; a2 = 16'd0; b2 = 16'd0;
        @(negedge clk);
        chk("reset_result", {32'd0, r0}, 64'd0);
        chk("reset_result_hi", {32'd0, h0}, 64'd0);
        chk("reset_valid", 64'(v0), 64'd0);
        chk("reset_busy", 64'(bz0), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run0(32'd3, 32'd5, 0);
        run0(32'hFFFF_FFF9, 32'd6, 0);
        run0(32'h8000_0000, 32'h8000_0000, 0);
        run0(32'd3, 32'd5, 10);
        repeat (40) @(posedge clk);

        // Reset in the middle of an operation: nothing may be reported for it.
        @(posedge clk); #1;
        a0 = 32'd3; b0 = 32'd5; nd0 = 1'b1;
        q[0].push_back(ref_mul(32'd3, 32'd5, 1'b1, 32));
        repeat (16) begin
            @(posedge clk); #1;
            nd0 = 1'b0;
        end
        chk("busy_before_reset", 64'(bz0), 64'd1);
        reset = 1'b0;
        q[0].delete();
        last[0] = 64'd0;
        @(posedge clk); #1;
        chk("busy_in_reset", 64'(bz0), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("after_abort_result", {32'd0, r0}, 64'd0);
        chk("after_abort_result_hi", {32'd0, h0}, 64'd0);
        chk("after_abort_valid", 64'(v0), 64'd0);
        chk("after_abort_busy", 64'(bz0), 64'd0);
        run0(32'd4, 32'd4, 0);

        fork
            b2b(1, 32, 1'b1, 9);
            b2b(2, 16, 1'b0, 5);
        join

        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("drained_d0", 64'(q[0].size()), 64'd0);
        chk("drained_d1", 64'(q[1].size()), 64'd0);
        chk("drained_d2", 64'(q[2].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/synthesijer_mul_seq.md
# synthesijer_mul_seq

Parametrised sequential integer multiplier, the multi-cycle successor to the single-cycle 32-bit multiplier primitive. It is used when a full-width combinational multiplier is too large or too slow to meet timing. It returns the full 2×WIDTH product, low half and high half, in WIDTH/BITS_PER_CYCLE+1 cycles. It keeps the same `nd`/`valid` operand/result convention, adds a `busy` flag, and lets the generated scheduler stall correctly.

## Interface
- WIDTH, 32: operand width in bits; ≥ 2.
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration; must divide WIDTH (1, 2, 4, 8 supported).
- SIGNED, 1: 1 = two's-complement operands and product; 0 = unsigned.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- a  in  WIDTH  multiplicand; sampled only on an accepted `nd`.
- b  in  WIDTH  multiplier; sampled only on an accepted `nd`.
- nd  in  1  new-data strobe; accepted only when `busy` = 0.
- result  out  WIDTH  low WIDTH bits of product; registered.
- result_hi  out  WIDTH  high WIDTH bits of product; registered.
- valid  out  1  one-cycle pulse: `result`/`result_hi` hold a new product.
- busy  out  1  high while an operation is in progress; `nd` is ignored.

## Operation
- ITER = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE → RUN on accepted `nd`.
  - RUN → IDLE after ITER iterations.
- Capture in IDLE with `nd` = 1:
  - If SIGNED = 1, store |a| and |b| as WIDTH-bit unsigned magnitudes. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits.
  - Store neg = a[MSB] XOR b[MSB]. neg = 0 when SIGNED = 0.
  - Clear the 2×WIDTH accumulator. Load iteration counter with ITER−1.
- RUN iteration, one per cycle:
  - Add (multiplicand magnitude × low BITS_PER_CYCLE bits of the multiplier register) into the accumulator at the current bit offset. A shift-add on the accumulator is equivalent and also acceptable.
  - Shift the multiplier register right by BITS_PER_CYCLE. Decrement the counter.
- Final iteration (counter = 0):
  - The product is the final accumulator, two's-complement negated over 2×WIDTH bits if neg = 1.
  - Load it into {result_hi, result}. Set `valid` = 1. State → IDLE.
- The product is exact modulo 2^(2×WIDTH); no overflow is possible.
- `result`/`result_hi` hold their value until the next completion. They never change in between.
- `nd` while `busy` = 1 is ignored. Operands are not queued and the running operation is not disturbed.
- `a`/`b` may change freely after the accept cycle.

## Timing
- Reset values: `result` = 0, `result_hi` = 0, `valid` = 0, `busy` = 0, state = IDLE, counter = 0, accumulator = 0.
- Reset asserted at any time, including mid-RUN, aborts the operation immediately. No `valid` is produced for the aborted operation; outputs return to reset values.
- `nd` accepted in cycle t → `busy` = 1 in cycles t+1 … t+ITER → `valid` = 1 and `busy` = 0 in cycle t+ITER+1.
- Latency is ITER+1 cycles. Examples: 33 for WIDTH = 32, BITS_PER_CYCLE = 1; 9 for BITS_PER_CYCLE = 4.
- `valid` is high for exactly one cycle per accepted `nd`.
- Back-to-back:
  - `nd` in the same cycle `valid` is high is accepted, since `busy` = 0 then.
  - Peak throughput is one product per ITER+1 cycles.
- `busy` is registered and driven from state only; no combinational path from `nd`.
- `nd` with `reset` asserted is ignored.

## Test plan
- Unsigned basic: SIGNED = 0, a = 3, b = 5, `nd` one cycle → after 33 cycles `valid` pulse, `result` = 0x0000000F, `result_hi` = 0; `busy` high exactly 32 cycles.
- Signed mixed: SIGNED = 1, a = −7 (0xFFFFFFF9), b = 6 → `result` = 0xFFFFFFD6, `result_hi` = 0xFFFFFFFF.
- Extremes:
  - SIGNED = 1, a = b = 0x80000000 → `result_hi` = 0x40000000, `result` = 0.
  - SIGNED = 0, a = b = 0xFFFFFFFF → `result_hi` = 0xFFFFFFFE, `result` = 0x00000001.
- Ignored `nd`: pulse `nd` with a = 2, b = 2 while `busy`, 10 cycles into a 3×5 operation → single `valid` with 15; no second `valid`; outputs stay 15.
- Reset mid-op: assert `reset` = 0 at iteration 16 of 3×5, release, wait 40 cycles → no `valid`, all outputs 0. A following 4×4 then yields 16 after 33 cycles.
- Back-to-back + parameter sweep: BITS_PER_CYCLE = 4, `nd` asserted again in each `valid` cycle, 100 random signed pairs → `valid` every 9 cycles, every product matches a 64-bit reference. Repeat with WIDTH = 16, SIGNED = 0.
